// File: rtl/set_state_wr_array_pkg.sv
// rtl/set_state_wr_array_pkg.sv - shared defaults and FSM encoding for the per-set state store
package set_state_wr_array_pkg;

    localparam int DEF_W        = 2;
    localparam int DEF_N        = 128;
    localparam int DEF_SEL_W    = 7;
    localparam int DEF_INIT_VAL = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/set_state_wr_array_wr_decoder128.sv
// rtl/set_state_wr_array_wr_decoder128.sv - index plus enable to one-hot write strobe
module wr_decoder128
    import set_state_wr_array_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     strobe
);

    always_comb begin
        strobe = '0;
        if (en) strobe = N'(1) << sel;
    end

endmodule

// File: rtl/set_state_wr_array.sv
// rtl/set_state_wr_array.sv - per-set state store write side with flush sequencer and read port
// Optional forwarding of same-edge writes/flush clears to the read port: STATE_ARRAY_FWD_EN
module set_state_wr_array
    import set_state_wr_array_pkg::*;
#(
    parameter int             W        = DEF_W,
    parameter int             N        = DEF_N,
    parameter int             SEL_W    = DEF_SEL_W,
    parameter logic [W-1:0]   INIT_VAL = W'(DEF_INIT_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    output logic             wr_ready,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [W-1:0]     rd_data,
    output logic             rd_valid,
    input  logic             flush_req,
    output logic             busy,
    output logic [N*W-1:0]   flat_out
);

    state_t           state;
    logic [SEL_W-1:0] cnt;
    logic [W-1:0]     ent [N];
    logic [N-1:0]     wr_strobe;
    logic             wr_acc;

    // Gating with rst_n keeps ready low for the whole reset, not just after the first edge.
    assign wr_ready = rst_n && (state == ST_IDLE);
    assign wr_acc   = wr_en && wr_ready;
    assign busy     = (state == ST_FLUSH);

    wr_decoder128 #(.N(N), .SEL_W(SEL_W)) u_dec (
        .en     (wr_acc),
        .sel    (wr_sel),
        .strobe (wr_strobe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (flush_req) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SEL_W'(N-1)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Writes only happen in IDLE and clears only in FLUSH, so the two never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) ent[i] <= INIT_VAL;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_strobe[i])
                    ent[i] <= wr_data;
                else if (state == ST_FLUSH && cnt == SEL_W'(i))
                    ent[i] <= INIT_VAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
`ifdef STATE_ARRAY_FWD_EN
                if (wr_acc && rd_sel == wr_sel)
                    rd_data <= wr_data;
                else if (state == ST_FLUSH && rd_sel == cnt)
                    rd_data <= INIT_VAL;
                else
                    rd_data <= ent[rd_sel];
`else
                rd_data <= ent[rd_sel];
`endif
            end
        end
    end

    always_comb begin
        flat_out = '0;
        for (int i = 0; i < N; i++) flat_out[i*W +: W] = ent[i];
    end

endmodule

// File: tb/tb_set_state_wr_array.sv
// tb/tb_set_state_wr_array.sv - scoreboard bench for set_state_wr_array
module tb_set_state_wr_array;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic         wr_ready;
    logic [6:0]   wr_sel = '0;
    logic [1:0]   wr_data = '0;
    logic         rd_en = 1'b0;
    logic [6:0]   rd_sel = '0;
    logic [1:0]   rd_data;
    logic         rd_valid;
    logic         flush_req = 1'b0;
    logic         busy;
    logic [255:0] flat_out;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [1:0] sb [$];

    set_state_wr_array dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_sel(wr_sel), .wr_data(wr_data), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .flush_req(flush_req),
        .busy(busy), .flat_out(flat_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pops one expected value.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n && rd_valid) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid with data %0h expected no read", rd_data);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] s, input logic [1:0] d);
        wr_en = 1'b1; wr_sel = s; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] s, input logic [1:0] e);
        rd_en = 1'b1; rd_sel = s; sb.push_back(e);
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
    endtask

    initial begin
        logic [255:0] snap;
        logic [255:0] all10;
        int busy_cnt;
        int bad;
        int lim;

        for (int i = 0; i < 128; i++) all10[i*2 +: 2] = 2'b10;

        #2;
        chk("reset_flat", flat_out, '0);
        chk("reset_busy", busy, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_wr_ready", wr_ready, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_reset_wr_ready", wr_ready, 1);

        // Write/read sel 5
        do_write(7'd20, 2'b01);
        snap = flat_out;
        do_write(7'd5, 2'b11);
        snap[11:10] = 2'b11;
        chk("wr5_flat", flat_out, snap);
        do_read(7'd5, 2'b11);
        do_read(7'd20, 2'b01);
        cyc();

        // Mid-run reset
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_flat", flat_out, '0);
        chk("midreset_busy", busy, 0);
        chk("midreset_rd_valid", rd_valid, 0);
        chk("midreset_wr_ready", wr_ready, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("release_wr_ready", wr_ready, 1);

        // Flush from all-2'b10
        for (int i = 0; i < 128; i++) do_write(7'(i), 2'b10);
        chk("fill_flat", flat_out, all10);
        pulse_flush();
        busy_cnt = 0;
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            if (busy) busy_cnt++;
            if (flat_out[k*2 +: 2] !== 2'b10) bad++;
            if (k == 10) begin
                wr_en = 1'b1; wr_sel = 7'd3; wr_data = 2'b01; flush_req = 1'b1;
            end
            if (k == 50) begin
                rd_en = 1'b1; rd_sel = 7'd50;
`ifdef STATE_ARRAY_FWD_EN
                sb.push_back(2'b00);
`else
                sb.push_back(2'b10);
`endif
            end
            if (k == 60) begin
                rd_en = 1'b1; rd_sel = 7'd100; sb.push_back(2'b10);
            end
            cyc();
            wr_en = 1'b0; flush_req = 1'b0; rd_en = 1'b0;
            if (flat_out[k*2 +: 2] !== 2'b00) bad++;
            if (k < 127 && flat_out[(k+1)*2 +: 2] !== 2'b10) bad++;
        end
        chk("flush_busy_cycles", busy_cnt, 128);
        chk("flush_progress_errors", bad, 0);
        chk("flush_done_busy", busy, 0);
        chk("flush_entry3_dropped", flat_out[7:6], 2'b00);
        chk("flush_all_zero", flat_out, '0);
        chk("flush_wr_ready", wr_ready, 1);

        // Collision sel 9
        do_write(7'd9, 2'b10);
        wr_en = 1'b1; wr_sel = 7'd9; wr_data = 2'b01;
        rd_en = 1'b1; rd_sel = 7'd9;
`ifdef STATE_ARRAY_FWD_EN
        sb.push_back(2'b01);
`else
        sb.push_back(2'b10);
`endif
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        do_read(7'd9, 2'b01);

        // Boundary indices
        do_write(7'd0, 2'b01);
        do_write(7'd127, 2'b11);
        chk("edge_sel0", flat_out[1:0], 2'b01);
        chk("edge_sel127", flat_out[255:254], 2'b11);
        do_read(7'd127, 2'b11);

        // Write and flush in the same cycle
        wr_en = 1'b1; wr_sel = 7'd64; wr_data = 2'b11; flush_req = 1'b1;
        cyc();
        wr_en = 1'b0; flush_req = 1'b0;
        chk("wrflush_landed", flat_out[129:128], 2'b11);
        chk("wrflush_busy", busy, 1);
        lim = 0;
        while (busy && lim < 300) begin cyc(); lim++; end
        chk("wrflush_bounded", lim, 128);
        chk("wrflush_cleared", flat_out, '0);

        // Abort a flush at cycle 40, then run a full one
        do_write(7'd90, 2'b10);
        pulse_flush();
        repeat (40) cyc();
        chk("abort_busy_before", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_flat", flat_out, '0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("abort_wr_ready", wr_ready, 1);
        do_write(7'd33, 2'b11);
        pulse_flush();
        busy_cnt = 0;
        lim = 0;
        while (busy && lim < 300) begin busy_cnt++; cyc(); lim++; end
        chk("refl_busy_cycles", busy_cnt, 128);
        chk("refl_cleared", flat_out, '0);

        repeat (3) cyc();
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
